// File: rtl/multiword_cla_sequencer_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead sequencer.
package multiword_cla_sequencer_pkg;

    localparam int unsigned NIB_W         = 4;
    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : multiword_cla_sequencer_pkg

// File: rtl/multiword_cla_sequencer_if.sv
// Operand/result bundle between a requester (master) and the sequencer (slave).
interface multiword_cla_sequencer_if
    import multiword_cla_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface : multiword_cla_sequencer_if

// File: rtl/cla4_nibble_adder.sv
// 4-bit adder with full generate/propagate lookahead for every internal carry.
module cla4_nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule : cla4_nibble_adder

// File: rtl/multiword_cla_sequencer.sv
// Multi-word add/subtract computed one nibble per cycle through a single shared
// 4-bit CLA; subtraction is a + ~b + 1, so cout=1 means no borrow.
module multiword_cla_sequencer
    import multiword_cla_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic                      clk,
    input logic                      rst_n,
    multiword_cla_sequencer_if.slave bus_io
);
    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned K_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

    if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [K_W-1:0]   k_q, k_d;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    assign nib_a = a_q[k_q*NIB_W +: NIB_W];
    assign nib_b = b_q[k_q*NIB_W +: NIB_W];

    cla4_nibble_adder u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Next-state: accept in IDLE/DONE, one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus_io.start) begin
                    a_d     = bus_io.a;
                    b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
                    carry_d = bus_io.sub ? 1'b1 : bus_io.cin;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[k_q*NIB_W +: NIB_W] = nib_sum;
                carry_d                   = nib_cout;
                k_d                       = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    // Status is decoded from the state flop only, never from inputs.
    assign bus_io.ready = (state_q != RUN);
    assign bus_io.busy  = (state_q == RUN);
    assign bus_io.done  = (state_q == DONE);
    assign bus_io.sum   = sum_q;
    assign bus_io.cout  = carry_q;
    assign bus_io.ovf   = ovf_q;
endmodule : multiword_cla_sequencer

// File: tb/tb_multiword_cla_sequencer.sv
// Directed-vector bench for the nibble-serial CLA sequencer (WIDTH=16).
module tb_multiword_cla_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multiword_cla_sequencer_if #(.WIDTH(16)) bus ();

    multiword_cla_sequencer #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Present an operation, let the next rising edge accept it, then scramble inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sub   = 1'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        start_op(v.a, v.b, v.sub, v.cin);
        check({name, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " sum"}, 32'(bus.sum), 32'(v.s));
        check({name, " cout"}, 32'(bus.cout), 32'(v.co));
        check({name, " ovf"}, 32'(bus.ovf), 32'(v.ov));
    endtask

    initial begin
        int   pulses;
        int   first;
        int   lat;
        logic [15:0] sum_at;
        vec_t v;

        checks = 0;
        errors = 0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);

        // First start lands on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done drop", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d hold sum", i), 32'(bus.sum), 32'(vecs[i].s));
        end

        repeat (3) @(posedge clk);
        #1;
        check("idle hold cout", 32'(bus.cout), 32'(vecs[9].co));
        check("idle hold ovf", 32'(bus.ovf), 32'(vecs[9].ov));
        check("idle ready", 32'(bus.ready), 32'd1);

        // Back-to-back: second start presented during the DONE cycle.
        v = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        run_vec("b2b first", v);
        check("b2b first ready", 32'(bus.ready), 32'd1);
        v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        run_vec("b2b second", v);

        repeat (2) @(posedge clk);
        #1;
        // Start pulsed two cycles into RUN must be ignored.
        start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        first  = 0;
        sum_at = '0;
        for (int c = 3; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                if (first == 0) begin
                    first  = c;
                    sum_at = bus.sum;
                end
            end
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore latency", 32'(first), 32'd4);
        check("ignore sum", 32'(sum_at), 32'h2222);
        check("ignore busy end", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of RUN.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort sum", 32'(bus.sum), 32'd0);
        check("abort cout", 32'(bus.cout), 32'd0);
        check("abort ovf", 32'(bus.ovf), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("abort held busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
        run_vec("post reset", v);
        wait_done(lat);
        check("post reset no extra done", 32'(lat), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_multiword_cla_sequencer

// File: doc/multiword_cla_sequencer.md
MULTIWORD_CLA_SEQUENCER -- requirements
Module: multiword_cla_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, shall set the operand width; it shall be a multiple of 4 and at least 8.
REQ-002 clk  input  1  sole clock; all state shall update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled on a clock edge.
REQ-005 sub  input  1  0 selects add; 1 selects subtract (a - b).
REQ-006 cin  input  1  carry-in for add; ignored when sub=1.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 ready  output  1  high when a start will be accepted.
REQ-010 busy  output  1  high while nibbles are being computed.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB (for subtract, 1 means no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 The FSM shall have exactly three states, IDLE, RUN and DONE; ready shall be 1 in IDLE and DONE, and busy shall be 1 only in RUN.
REQ-016 On an edge with start=1 and ready=1, the block shall:
- capture a into a_reg;
- capture b into b_reg, or ~b when sub=1;
- set the carry register to cin, or to 1 when sub=1;
- clear nibble index k to 0 and sum_reg to 0;
- enter RUN.
REQ-017 On each RUN edge, the block shall:
- compute nibble k from a_reg[4k+3:4k], b_reg[4k+3:4k] and the carry register, using one shared 4-bit carry-lookahead adder;
- write the result into sum_reg[4k+3:4k];
- load that nibble's carry-out into the carry register;
- increment k.
REQ-018 On the RUN edge that processes k = WIDTH/4-1, the block shall:
- latch ovf = (a_reg[MSB] == b_reg[MSB]) and (sum MSB != a_reg[MSB]);
- enter DONE.
REQ-019 cout shall equal the final carry register.
REQ-020 done shall be 1 for exactly the one cycle spent in DONE.
REQ-021 Latency: done shall assert WIDTH/4 clock cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-022 From DONE, start=1 shall be accepted directly (back-to-back operation); otherwise the next state shall be IDLE.
REQ-023 sum, cout and ovf shall hold their last result through IDLE until the next accepted start.
REQ-024 start during RUN shall be ignored, with no effect on registers or on k.
REQ-025 Changes to a, b, sub and cin after the accepting edge shall not affect the result in progress.
REQ-026 Arithmetic shall be modulo 2^WIDTH; no saturation.

Reset
REQ-027 While rst_n=0, regardless of clk, the block shall force:
- state=IDLE, k=0, carry register=0;
- sum=0, cout=0, ovf=0, done=0, busy=0, ready=1.
REQ-028 Reset asserted mid-RUN shall abort the operation, with no done pulse after release.
REQ-029 The first start shall be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package shall hold:
- the FSM state type (IDLE, RUN, DONE);
- the nibble width constant 4;
- the default WIDTH.
REQ-031 The 4-bit carry-lookahead adder shall be one sub-module, cla4_nibble_adder, instantiated exactly once, with ports a[3:0], b[3:0], cin, sum[3:0], cout and full generate/propagate lookahead.
REQ-032 No combinational path shall exist from a, b, sub, cin or start to any output.

Verification
REQ-033 Add 0x1234 + 0x4321, cin=0 -> after 4 cycles: done=1, sum=0x5555, cout=0, ovf=0.
REQ-034 Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (tests carry ripple across all nibbles).
REQ-035 Subtract sub=1, 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0; and 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-036 Add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1; then start held in the DONE cycle with 0x0001 + 0x0001 -> second done exactly 4 cycles later with sum=0x0002.
REQ-037 Start 0x1111 + 0x1111, then pulse start with 0xFFFF + 0xFFFF two cycles later -> second start ignored; sum=0x2222, one done pulse only.
REQ-038 Reset mid-RUN -> all outputs at reset values immediately, no done pulse; a new add 0x0003 + 0x0004 after release -> sum=0x0007.
